// File: rtl/instr_fetch_unit.sv
// Instruction fetch stage: PC, req/ready fetch from instruction memory, instruction register.
// Optional performance counters (retires, stalled cycles) are built when IFETCH_PERF_EN is defined.
module instr_fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ready,
    input  logic [31:0] imem_rdata,
    input  logic        stall,
    input  logic        branch,
    input  logic        zero,
    input  logic        jump,
    output logic        instr_valid,
    output logic [31:0] instr,
    output logic [5:0]  op_out,
    output logic [5:0]  func_out,
    output logic [31:0] pc_out,
    output logic [31:0] pc_plus4,
    output logic [31:0] fetch_count,
    output logic [31:0] stall_cycles
);

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        VALID
    } state_t;

    localparam logic [31:0] RESET_PC_ALIGNED = {RESET_PC[31:2], 2'b00};

    state_t      state;
    state_t      state_next;
    logic [31:0] pc;
    logic [31:0] pc_next;
    logic [31:0] instr_reg;
    logic [31:0] branch_target;
    logic [31:0] jump_target;
    logic        load;
    logic        retire;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        imem_req   = 1'b0;
        load       = 1'b0;
        retire     = 1'b0;
        case (state)
            IDLE: begin
                state_next = REQ;
            end
            REQ: begin
                imem_req = 1'b1;
                if (imem_ready) begin
                    load       = 1'b1;
                    state_next = VALID;
                end
            end
            VALID: begin
                if (!stall) begin
                    retire     = 1'b1;
                    state_next = REQ;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Jump outranks a taken branch; both targets are relative to the retiring instruction.
    always_comb begin
        branch_target = pc_plus4 + {{14{instr_reg[15]}}, instr_reg[15:0], 2'b00};
        jump_target   = {pc_plus4[31:28], instr_reg[25:0], 2'b00};
        if (jump) begin
            pc_next = jump_target;
        end else if (branch && zero) begin
            pc_next = branch_target;
        end else begin
            pc_next = pc_plus4;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pc <= RESET_PC_ALIGNED;
        end else if (retire) begin
            pc <= pc_next;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            instr_reg <= 32'h0;
        end else if (load) begin
            instr_reg <= imem_rdata;
        end
    end

    assign pc_out      = pc;
    assign imem_addr   = pc;
    assign pc_plus4    = pc + 32'd4;
    assign instr       = instr_reg;
    assign instr_valid = (state == VALID);
    assign op_out      = instr_reg[31:26];
    assign func_out    = instr_reg[5:0];

`ifdef IFETCH_PERF_EN
    logic [31:0] fetch_cnt;
    logic [31:0] stall_cnt;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            fetch_cnt <= 32'h0;
            stall_cnt <= 32'h0;
        end else begin
            if (retire) begin
                fetch_cnt <= fetch_cnt + 32'd1;
            end
            if ((state == VALID) && stall) begin
                stall_cnt <= stall_cnt + 32'd1;
            end
        end
    end

    assign fetch_count  = fetch_cnt;
    assign stall_cycles = stall_cnt;
`else
    assign fetch_count  = 32'h0;
    assign stall_cycles = 32'h0;
`endif

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed, table-driven bench for instr_fetch_unit, plus hand-written reset, jump and PC-wrap sequences.
// A second instance with RESET_PC=0x4000_0003 covers reset alignment and the high-region jump.
module tb_instr_fetch_unit;

`ifdef IFETCH_PERF_EN
    localparam int PERF = 1;
`else
    localparam int PERF = 0;
`endif

    localparam logic [31:0] A0 = 32'h2108_0005;
    localparam logic [31:0] A1 = 32'h8C62_0023;
    localparam logic [31:0] A2 = 32'h0043_082A;
    localparam logic [31:0] A3 = 32'hAC43_FFE7;
    localparam logic [31:0] A4 = 32'h1000_FFFE;
    localparam logic [31:0] JW = 32'h0800_0010;
    localparam logic [31:0] BW = 32'h1000_FFEE;

    logic        clk = 1'b0;
    logic        reset;
    logic        imem_ready;
    logic [31:0] imem_rdata;
    logic        stall;
    logic        branch;
    logic        zero;
    logic        jump;

    logic        imem_req;
    logic [31:0] imem_addr;
    logic        instr_valid;
    logic [31:0] instr;
    logic [5:0]  op_out;
    logic [5:0]  func_out;
    logic [31:0] pc_out;
    logic [31:0] pc_plus4;
    logic [31:0] fetch_count;
    logic [31:0] stall_cycles;

    logic        hi_req;
    logic [31:0] hi_addr;
    logic        hi_valid;
    logic [31:0] hi_instr;
    logic [5:0]  hi_op;
    logic [5:0]  hi_func;
    logic [31:0] hi_pc;
    logic [31:0] hi_pc_plus4;
    logic [31:0] hi_fetch_count;
    logic [31:0] hi_stall_cycles;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    instr_fetch_unit #(.RESET_PC(32'h0000_0000)) dut (
        .clk(clk), .reset(reset),
        .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_ready(imem_ready), .imem_rdata(imem_rdata),
        .stall(stall), .branch(branch), .zero(zero), .jump(jump),
        .instr_valid(instr_valid), .instr(instr),
        .op_out(op_out), .func_out(func_out),
        .pc_out(pc_out), .pc_plus4(pc_plus4),
        .fetch_count(fetch_count), .stall_cycles(stall_cycles)
    );

    instr_fetch_unit #(.RESET_PC(32'h4000_0003)) dut_hi (
        .clk(clk), .reset(reset),
        .imem_req(hi_req), .imem_addr(hi_addr),
        .imem_ready(imem_ready), .imem_rdata(imem_rdata),
        .stall(stall), .branch(branch), .zero(zero), .jump(jump),
        .instr_valid(hi_valid), .instr(hi_instr),
        .op_out(hi_op), .func_out(hi_func),
        .pc_out(hi_pc), .pc_plus4(hi_pc_plus4),
        .fetch_count(hi_fetch_count), .stall_cycles(hi_stall_cycles)
    );

    typedef struct {
        logic        ready;
        logic        stl;
        logic        br;
        logic        zr;
        logic        jp;
        logic [31:0] rdata;
        logic        exp_req;
        logic        exp_valid;
        logic [31:0] exp_addr;
        logic [31:0] exp_instr;
        logic [31:0] exp_fc;
        logic [31:0] exp_sc;
    } vec_t;

    vec_t vecs[20];

    function automatic vec_t mk(logic rdy, logic stl, logic br, logic zr, logic jp,
                                logic [31:0] rd, logic ereq, logic evld,
                                logic [31:0] eaddr, logic [31:0] einstr, int efc, int esc);
        vec_t v;
        v.ready     = rdy;
        v.stl       = stl;
        v.br        = br;
        v.zr        = zr;
        v.jp        = jp;
        v.rdata     = rd;
        v.exp_req   = ereq;
        v.exp_valid = evld;
        v.exp_addr  = eaddr;
        v.exp_instr = einstr;
        v.exp_fc    = 32'(efc * PERF);
        v.exp_sc    = 32'(esc * PERF);
        return v;
    endfunction

    task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic apply_stimulus(input vec_t v);
        imem_ready = v.ready;
        stall      = v.stl;
        branch     = v.br;
        zero       = v.zr;
        jump       = v.jp;
        imem_rdata = v.rdata;
    endtask

    task automatic idle_inputs();
        imem_ready = 1'b0;
        stall      = 1'b0;
        branch     = 1'b0;
        zero       = 1'b0;
        jump       = 1'b0;
    endtask

    initial begin
        logic [31:0] ei;
        //        rdy stl br zr jp rdata  req vld addr          instr  fc sc
        vecs[0]  = mk(1, 0, 1, 1, 1, A0,  1, 0, 32'h0000_0000, 32'h0, 0, 0);
        vecs[1]  = mk(1, 0, 1, 1, 1, A0,  0, 1, 32'h0000_0000, A0,    0, 0);
        vecs[2]  = mk(0, 0, 0, 0, 0, A1,  1, 0, 32'h0000_0004, A0,    1, 0);
        vecs[3]  = mk(1, 0, 0, 0, 0, A1,  0, 1, 32'h0000_0004, A1,    1, 0);
        vecs[4]  = mk(0, 0, 0, 0, 0, A2,  1, 0, 32'h0000_0008, A1,    2, 0);
        vecs[5]  = mk(1, 0, 0, 0, 0, A2,  0, 1, 32'h0000_0008, A2,    2, 0);
        vecs[6]  = mk(0, 0, 0, 0, 0, A3,  1, 0, 32'h0000_000C, A2,    3, 0);
        vecs[7]  = mk(0, 1, 0, 0, 0, A3,  1, 0, 32'h0000_000C, A2,    3, 0);
        vecs[8]  = mk(0, 0, 0, 0, 0, A3,  1, 0, 32'h0000_000C, A2,    3, 0);
        vecs[9]  = mk(0, 0, 0, 0, 0, A3,  1, 0, 32'h0000_000C, A2,    3, 0);
        vecs[10] = mk(1, 1, 0, 0, 0, A3,  0, 1, 32'h0000_000C, A3,    3, 0);
        vecs[11] = mk(0, 1, 0, 0, 0, A0,  0, 1, 32'h0000_000C, A3,    3, 1);
        vecs[12] = mk(1, 1, 1, 1, 1, A0,  0, 1, 32'h0000_000C, A3,    3, 2);
        vecs[13] = mk(0, 0, 0, 0, 0, A4,  1, 0, 32'h0000_0010, A3,    4, 2);
        vecs[14] = mk(1, 0, 0, 0, 0, A4,  0, 1, 32'h0000_0010, A4,    4, 2);
        vecs[15] = mk(0, 0, 1, 1, 0, A4,  1, 0, 32'h0000_000C, A4,    5, 2);
        vecs[16] = mk(1, 0, 0, 0, 0, A4,  0, 1, 32'h0000_000C, A4,    5, 2);
        vecs[17] = mk(0, 0, 1, 0, 0, A4,  1, 0, 32'h0000_0010, A4,    6, 2);
        vecs[18] = mk(1, 0, 0, 0, 0, A4,  0, 1, 32'h0000_0010, A4,    6, 2);
        vecs[19] = mk(0, 0, 1, 0, 0, A4,  1, 0, 32'h0000_0014, A4,    7, 2);

        reset      = 1'b1;
        imem_rdata = 32'h0;
        idle_inputs();
        repeat (2) @(negedge clk);

        check_output("rst.req", {31'h0, imem_req}, 32'h0);
        check_output("rst.valid", {31'h0, instr_valid}, 32'h0);
        check_output("rst.addr", imem_addr, 32'h0000_0000);
        check_output("rst.pc_plus4", pc_plus4, 32'h0000_0004);
        check_output("rst.instr", instr, 32'h0);
        check_output("rst.op", {26'h0, op_out}, 32'h0);
        check_output("rst.func", {26'h0, func_out}, 32'h0);
        check_output("rst.fetch_count", fetch_count, 32'h0);
        check_output("rst.stall_cycles", stall_cycles, 32'h0);
        check_output("rst.hi_addr", hi_addr, 32'h4000_0000);

        reset = 1'b0;
        for (int i = 0; i < 20; i++) begin
            apply_stimulus(vecs[i]);
            @(negedge clk);
            ei = vecs[i].exp_instr;
            check_output($sformatf("v%0d.req", i), {31'h0, imem_req}, {31'h0, vecs[i].exp_req});
            check_output($sformatf("v%0d.valid", i), {31'h0, instr_valid}, {31'h0, vecs[i].exp_valid});
            check_output($sformatf("v%0d.addr", i), imem_addr, vecs[i].exp_addr);
            check_output($sformatf("v%0d.pc_out", i), pc_out, vecs[i].exp_addr);
            check_output($sformatf("v%0d.pc_plus4", i), pc_plus4, vecs[i].exp_addr + 32'd4);
            check_output($sformatf("v%0d.instr", i), instr, ei);
            check_output($sformatf("v%0d.op", i), {26'h0, op_out}, {26'h0, ei[31:26]});
            check_output($sformatf("v%0d.func", i), {26'h0, func_out}, {26'h0, ei[5:0]});
            check_output($sformatf("v%0d.fetch_count", i), fetch_count, vecs[i].exp_fc);
            check_output($sformatf("v%0d.stall_cycles", i), stall_cycles, vecs[i].exp_sc);
        end

        // Reset asserted in REQ while memory answers: everything clears at once.
        idle_inputs();
        imem_ready = 1'b1;
        imem_rdata = A0;
        #2 reset = 1'b1;
        #1;
        check_output("midrst.req", {31'h0, imem_req}, 32'h0);
        check_output("midrst.valid", {31'h0, instr_valid}, 32'h0);
        check_output("midrst.instr", instr, 32'h0);
        check_output("midrst.addr", imem_addr, 32'h0000_0000);
        check_output("midrst.fetch_count", fetch_count, 32'h0);
        @(negedge clk);
        check_output("midrst.instr_held", instr, 32'h0);
        reset = 1'b0;
        @(negedge clk);
        check_output("late_ready.req", {31'h0, imem_req}, 32'h1);
        check_output("late_ready.valid", {31'h0, instr_valid}, 32'h0);
        check_output("late_ready.instr", instr, 32'h0);

        // Jump with a simultaneous taken branch, on both PC regions.
        imem_rdata = JW;
        @(negedge clk);
        check_output("jump.fetch_valid", {31'h0, instr_valid}, 32'h1);
        check_output("jump.op", {26'h0, op_out}, 32'h2);
        check_output("jump.hi_pc", hi_pc, 32'h4000_0000);
        imem_ready = 1'b0;
        jump       = 1'b1;
        branch     = 1'b1;
        zero       = 1'b1;
        @(negedge clk);
        check_output("jump.addr", imem_addr, 32'h0000_0040);
        check_output("jump.hi_addr", hi_addr, 32'h4000_0040);
        check_output("jump.req", {31'h0, imem_req}, 32'h1);

        // Taken branch to the top of memory, then sequential wrap to 0.
        idle_inputs();
        imem_ready = 1'b1;
        imem_rdata = BW;
        @(negedge clk);
        check_output("wrap.fetch_instr", instr, BW);
        imem_ready = 1'b0;
        branch     = 1'b1;
        zero       = 1'b1;
        @(negedge clk);
        check_output("wrap.top_addr", imem_addr, 32'hFFFF_FFFC);
        check_output("wrap.pc_plus4", pc_plus4, 32'h0000_0000);
        idle_inputs();
        imem_ready = 1'b1;
        imem_rdata = A0;
        @(negedge clk);
        check_output("wrap.top_instr", instr, A0);
        imem_ready = 1'b0;
        @(negedge clk);
        check_output("wrap.next_addr", imem_addr, 32'h0000_0000);
        check_output("wrap.req", {31'h0, imem_req}, 32'h1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
